// File: rtl/tdes_sequencer.sv
// Runs one shared single-DES core through the three Triple-DES (EDE) passes.
// Define TDES_TIMEOUT_EN to add a per-pass des_done watchdog.
module tdes_sequencer
`ifdef TDES_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1023
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        decrypt_mode,
    input  logic        abort,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [1:0]  key_idx,
    output logic [63:0] des_din,
    input  logic [63:0] des_dout,
    input  logic        des_done,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic        busy,
    output logic        overrun,
    output logic        error
);

    typedef enum logic [1:0] {
        COLLECT,
        RUN_START,
        RUN_WAIT,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  pass_cnt_q, pass_cnt_d;
    logic [63:0] block_q, block_d;
    logic        mode_q, mode_d;
    logic [1:0]  key_idx_q, key_idx_d;
    logic        dec_q, dec_d;
    logic        overrun_q, overrun_d;
    logic        error_q, error_d;
    logic        timeout;

`ifdef TDES_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pass_cnt_d = pass_cnt_q;
        block_d    = block_q;
        mode_d     = mode_q;
        key_idx_d  = key_idx_q;
        dec_d      = dec_q;
        overrun_d  = rx_byte_valid && (state_q != COLLECT);
        timeout    = 1'b0;
`ifdef TDES_TIMEOUT_EN
        wdog_d = wdog_q;
        if (state_q == RUN_START) begin
            wdog_d = '0;
        end else if (state_q == RUN_WAIT) begin
            wdog_d = wdog_q + 1'b1;
        end
        timeout = (state_q == RUN_WAIT) && !des_done &&
                  (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif
        error_d = timeout;

        unique case (state_q)
            COLLECT: begin
                if (rx_byte_valid) begin
                    block_d    = {block_q[55:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        mode_d     = decrypt_mode;
                        pass_cnt_d = 2'd0;
                        state_d    = RUN_START;
                    end
                end
            end
            RUN_START: begin
                state_d = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (des_done) begin
                    block_d = des_dout;
                    if (pass_cnt_q < 2'd2) begin
                        pass_cnt_d = pass_cnt_q + 2'd1;
                        state_d    = RUN_START;
                    end else begin
                        byte_cnt_d = 3'd0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tx_byte_ready) begin
                    block_d    = {block_q[55:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        state_d = COLLECT;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        // abort/timeout win over every same-cycle event; block is kept
        if (abort || timeout) begin
            state_d    = COLLECT;
            byte_cnt_d = 3'd0;
            pass_cnt_d = 2'd0;
            block_d    = block_q;
            mode_d     = mode_q;
        end

        // EDE order: K1,K2,K3 forward; K3,K2,K1 reverse; middle pass inverted
        if (state_d == RUN_START) begin
            key_idx_d = mode_d ? (2'd3 - pass_cnt_d) : (pass_cnt_d + 2'd1);
            dec_d     = mode_d ^ pass_cnt_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            byte_cnt_q <= 3'd0;
            pass_cnt_q <= 2'd0;
            block_q    <= 64'd0;
            mode_q     <= 1'b0;
            key_idx_q  <= 2'd1;
            dec_q      <= 1'b0;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
`ifdef TDES_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            block_q    <= block_d;
            mode_q     <= mode_d;
            key_idx_q  <= key_idx_d;
            dec_q      <= dec_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
`ifdef TDES_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign des_start     = (state_q == RUN_START);
    assign des_decrypt   = dec_q;
    assign key_idx       = key_idx_q;
    assign des_din       = block_q;
    assign tx_byte_valid = (state_q == DRAIN);
    assign tx_byte       = tx_byte_valid ? block_q[63:56] : 8'h00;
    assign busy          = (state_q != COLLECT);
    assign overrun       = overrun_q;
    assign error         = error_q;

endmodule

// File: tb/tb_tdes_sequencer.sv
// Bench for tdes_sequencer: randomized EDE transactions against a reference
// model, plus directed overrun, abort, backpressure, reset and timeout cases.
module tb_tdes_sequencer;

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT    = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT    = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        decrypt_mode;
    logic        abort;
    logic        bench_abort;
    logic        resp_abort;
    logic        des_start;
    logic        des_decrypt;
    logic [1:0]  key_idx;
    logic [63:0] des_din;
    logic [63:0] des_dout;
    logic        des_done;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;
    logic        busy;
    logic        overrun;
    logic        error;

    always #5 clk = ~clk;
    assign abort = bench_abort | resp_abort;

`ifdef TDES_TIMEOUT_EN
    tdes_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
    tdes_sequencer dut (
`endif
        .clk(clk), .rst(rst),
        .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
        .decrypt_mode(decrypt_mode), .abort(abort),
        .des_start(des_start), .des_decrypt(des_decrypt),
        .key_idx(key_idx), .des_din(des_din),
        .des_dout(des_dout), .des_done(des_done),
        .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
        .tx_byte_ready(tx_byte_ready), .busy(busy),
        .overrun(overrun), .error(error)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] keys [0:3];
    logic [2:0]  start_log [$];
    logic [2:0]  enc_seq [3] = '{3'b010, 3'b101, 3'b110};
    logic [2:0]  dec_seq [3] = '{3'b111, 3'b100, 3'b011};
    bit          hang = 1'b0;
    int          abort_pass = -1;
    bit          abort_fired = 1'b0;
    int          lat_min = 0;
    int          lat_max = 4;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [63:0] res;
    int          ovr_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // single-DES stand-in: known answers for the reference key, keyed
    // invertible permutation for everything else
    function automatic logic [63:0] des_model(input logic [63:0] k,
                                              input bit dec,
                                              input logic [63:0] x);
        logic [63:0] sw;
        logic [63:0] t;
        sw = {k[31:0], k[63:32]};
        if (k == K_STD && !dec && x == PT) return CT;
        if (k == K_STD && dec && x == CT) return PT;
        if (!dec) begin
            t = x ^ k;
            return {t[50:0], t[63:51]} ^ sw;
        end
        t = x ^ sw;
        return {t[12:0], t[63:13]} ^ k;
    endfunction

    function automatic logic [63:0] tdes_ref(input bit mode,
                                             input logic [63:0] x);
        if (!mode)
            return des_model(keys[3], 1'b0,
                   des_model(keys[2], 1'b1,
                   des_model(keys[1], 1'b0, x)));
        return des_model(keys[1], 1'b1,
               des_model(keys[2], 1'b0,
               des_model(keys[3], 1'b1, x)));
    endfunction

    // DES core responder
    initial begin
        des_done   = 1'b0;
        des_dout   = '0;
        resp_abort = 1'b0;
        forever begin
            @(negedge clk);
            des_done   = 1'b0;
            resp_abort = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    des_done = 1'b1;
                    des_dout = res;
                    pend     = 1'b0;
                    if (abort_pass == start_log.size()) begin
                        resp_abort  = 1'b1;
                        abort_fired = 1'b1;
                    end
                end else begin
                    cnt--;
                end
            end
            if (des_start) begin
                start_log.push_back({key_idx, des_decrypt});
                if (!hang) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(lat_min, lat_max);
                    res  = des_model(keys[key_idx], des_decrypt, des_din);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (error) err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench stuck");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [63:0] blk, input bit mode,
                              input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte       = blk[63-8*i -: 8];
            decrypt_mode  = mode;
            @(negedge clk);
            rx_byte_valid = 1'b0;
            if (i < nb - 1) tick($urandom_range(0, gap));
        end
    endtask

    task automatic wait_drain(input int bound);
        int g = 0;
        while (!tx_byte_valid && g < bound) begin
            @(negedge clk);
            g++;
        end
        if (!tx_byte_valid) check("wait_drain", 0, 1);
    endtask

    task automatic drain(output logic [63:0] got, input int gap);
        int n = 0;
        int g = 0;
        got = '0;
        while (n < 8 && g < 400) begin
            if (tx_byte_valid && $urandom_range(0, gap) == 0) begin
                got = {got[55:0], tx_byte};
                tx_byte_ready = 1'b1;
                n++;
            end
            @(negedge clk);
            tx_byte_ready = 1'b0;
            g++;
        end
        if (n != 8) check("drain_count", n, 8);
    endtask

    task automatic run_txn(input string tag, input logic [63:0] blk,
                           input bit mode, input int gap,
                           input logic [63:0] exp);
        logic [63:0] got;
        start_log.delete();
        send_bytes(blk, mode, 8, gap);
        check({tag, "_start_latency"}, des_start, 1);
        wait_drain(300);
        check({tag, "_pass_count"}, start_log.size(), 3);
        for (int p = 0; p < 3; p++) begin
            if (p < start_log.size())
                check($sformatf("%s_pass%0d_key_dir", tag, p + 1),
                      start_log[p], mode ? dec_seq[p] : enc_seq[p]);
        end
        drain(got, gap);
        check({tag, "_result"}, got, exp);
        check({tag, "_idle_after"}, {busy, tx_byte_valid}, 0);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] blk;
        bit          mode;
        int          o0;
        int          e0;
        int          g;
        int          held;

        rst = 1'b1;
        rx_byte_valid = 1'b0;
        rx_byte = 8'h00;
        decrypt_mode = 1'b0;
        bench_abort = 1'b0;
        tx_byte_ready = 1'b0;
        keys[0] = '0;
        keys[1] = K_STD;
        keys[2] = K_STD;
        keys[3] = K_STD;
        tick(3);

        check("rst_busy", busy, 0);
        check("rst_key_idx", key_idx, 1);
        check("rst_start_dec", {des_start, des_decrypt}, 0);
        check("rst_tx", {tx_byte_valid, tx_byte}, 0);
        check("rst_pulses", {overrun, error}, 0);
        check("rst_din", des_din, 0);
        rst = 1'b0;
        tick(1);

        run_txn("kat_enc", PT, 1'b0, 0, CT);
        run_txn("kat_dec", CT, 1'b1, 2, PT);

        // rx bytes while running and while draining are dropped
        o0 = ovr_cnt;
        start_log.delete();
        send_bytes(PT, 1'b0, 8, 0);
        tick(1);
        rx_byte_valid = 1'b1;
        rx_byte = 8'hAA;
        tick(1);
        rx_byte_valid = 1'b0;
        wait_drain(300);
        rx_byte_valid = 1'b1;
        rx_byte = 8'h55;
        tick(1);
        rx_byte_valid = 1'b0;
        drain(got, 1);
        tick(2);
        check("ovr_result", got, CT);
        check("ovr_pulses", ovr_cnt - o0, 2);

        // backpressure
        send_bytes(PT, 1'b0, 8, 0);
        wait_drain(300);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_byte_valid && tx_byte == 8'h85) held++;
            tick(1);
        end
        check("bp_hold", held, 20);
        drain(got, 0);
        check("bp_result", got, CT);
        check("bp_idle", busy, 0);

        // reset mid-run with a DES completion still pending
        lat_min = 4;
        lat_max = 4;
        start_log.delete();
        send_bytes(CT, 1'b1, 8, 0);
        tick(1);
        check("midrst_key_before", key_idx, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_state", {busy, des_start, tx_byte_valid}, 0);
        check("midrst_key_dir", {key_idx, des_decrypt}, 3'b010);
        check("midrst_din", des_din, 0);
        tick(6);
        check("midrst_done_ignored", busy, 0);
        check("midrst_starts", start_log.size(), 1);
        lat_min = 0;
        lat_max = 4;

        for (int k = 1; k <= 3; k++) keys[k] = {$urandom, $urandom};

        for (int t = 0; t < 8; t++) begin
            blk  = {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", t), blk, mode, 2,
                    tdes_ref(mode, blk));
        end

        // abort after 4 bytes, then a full new block
        send_bytes({$urandom, $urandom}, 1'b0, 4, 1);
        bench_abort = 1'b1;
        tick(1);
        bench_abort = 1'b0;
        check("abort4_idle", busy, 0);
        blk = {$urandom, $urandom};
        run_txn("abort4_next", blk, 1'b1, 1, tdes_ref(1'b1, blk));

        // abort together with the 8th byte
        start_log.delete();
        send_bytes({$urandom, $urandom}, 1'b0, 7, 0);
        rx_byte_valid = 1'b1;
        rx_byte = 8'h3C;
        bench_abort = 1'b1;
        tick(1);
        rx_byte_valid = 1'b0;
        bench_abort = 1'b0;
        check("abort8_no_start", {des_start, busy}, 0);
        blk = {$urandom, $urandom};
        run_txn("abort8_next", blk, 1'b0, 0, tdes_ref(1'b0, blk));

        // abort in the same cycle as the pass-2 completion
        start_log.delete();
        abort_fired = 1'b0;
        abort_pass = 2;
        send_bytes({$urandom, $urandom}, 1'b0, 8, 0);
        g = 0;
        while (!abort_fired && g < 100) begin
            tick(1);
            g++;
        end
        check("abortd_fired", abort_fired, 1);
        abort_pass = -1;
        tick(1);
        check("abortd_idle", {busy, tx_byte_valid}, 0);
        tick(20);
        check("abortd_starts", start_log.size(), 2);
        check("abortd_still_idle", busy, 0);

        // DES core that never answers
        hang = 1'b1;
        e0 = err_cnt;
        start_log.delete();
        send_bytes(PT, 1'b0, 8, 0);
`ifdef TDES_TIMEOUT_EN
        g = 0;
        while (busy && g < 100) begin
            tick(1);
            g++;
        end
        check("to_cycles", g, 17);
        tick(2);
        check("to_error_pulses", err_cnt - e0, 1);
        check("to_idle", busy, 0);
        check("to_starts", start_log.size(), 1);
`else
        tick(40);
        check("hang_busy", busy, 1);
        check("hang_no_error", err_cnt - e0, 0);
        bench_abort = 1'b1;
        tick(1);
        bench_abort = 1'b0;
        check("hang_abort_idle", busy, 0);
`endif
        hang = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdes_sequencer.md
Name: tdes_sequencer

Overview:
- Sequences one shared single-DES core through the three passes of Triple-DES (EDE).
- Sits between the I2C slave byte path and the DES core.
- Collects 8 received bytes into a 64-bit block, then runs pass 1..3 with the correct key index and direction.
- Streams the 8 result bytes back to the I2C transmit path, MSB first.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles to wait for des_done in one pass. Used only when TDES_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_byte_valid  in  1  one-cycle pulse; rx_byte holds a received data byte
- rx_byte  in  8  received byte
- decrypt_mode  in  1  0 = encrypt (E-K1, D-K2, E-K3); 1 = decrypt (D-K3, E-K2, D-K1)
- abort  in  1  I2C stop/restart; drops the transaction
- des_start  out  1  one-cycle pulse; starts the DES core
- des_decrypt  out  1  direction for the current pass
- key_idx  out  2  key select for the current pass: 1, 2 or 3 (0 never used)
- des_din  out  64  DES input block, stable from des_start until des_done
- des_dout  in  64  DES result, valid when des_done = 1
- des_done  in  1  one-cycle completion pulse from the DES core
- tx_byte  out  8  byte offered to the transmit path
- tx_byte_valid  out  1  tx_byte is valid
- tx_byte_ready  in  1  one-cycle pulse; transmit path consumed tx_byte
- busy  out  1  high in every state except COLLECT
- overrun  out  1  one-cycle pulse; an rx byte was dropped
- error  out  1  one-cycle pulse; pass timeout (macro only)

Behaviour:
- Reset:
  - state = COLLECT; byte_cnt = 0; pass_cnt = 0; block = 0; mode_q = 0.
  - All outputs 0, except key_idx = 1.
- States:
  - COLLECT, RUN_START, RUN_WAIT, DRAIN.
  - Encoding is free; add no other states.
- COLLECT:
  - Each rx_byte_valid shifts rx_byte into block[7:0] with a left shift of 8. The first byte ends up in block[63:56].
  - byte_cnt increments on each byte.
  - On the 8th byte: latch decrypt_mode into mode_q, set pass_cnt = 0, go to RUN_START next cycle.
- RUN_START (exactly 1 cycle):
  - des_start = 1; des_din = block.
  - key_idx and des_decrypt come from pass_cnt and mode_q per the decrypt_mode table above.
  - Always go to RUN_WAIT.
- RUN_WAIT:
  - des_din, key_idx and des_decrypt stay held.
  - On des_done: block <= des_dout.
  - If pass_cnt < 2: pass_cnt increments and next state is RUN_START. Otherwise next state is DRAIN with byte_cnt = 0.
- DRAIN:
  - tx_byte_valid = 1; tx_byte = block[63:56].
  - On tx_byte_ready: block shifts left by 8 and byte_cnt increments.
  - After the 8th ready pulse: byte_cnt = 0, go to COLLECT; tx_byte_valid is low in that cycle.
- Latency: 8th rx byte accepted in cycle N → first des_start in cycle N+1. Each following pass starts 1 cycle after the previous des_done.
- rx_byte_valid outside COLLECT: byte dropped; overrun pulses 1 cycle; state unchanged.
- abort, any state:
  - Next state is COLLECT; byte_cnt = 0; pass_cnt = 0.
  - des_dout is ignored; tx_byte_valid drops the next cycle; block is not cleared.
- Same-cycle priorities:
  - abort beats des_done.
  - abort beats the 8th rx byte: no RUN_START follows.
  - abort beats tx_byte_ready.
- des_done outside RUN_WAIT is ignored.
- tx_byte_ready outside DRAIN is ignored.
- key_idx holds its last value outside RUN_*.
- rst mid-operation returns everything to reset values on the next edge. A pending des_done afterwards is ignored.

Optional Feature:
- TDES_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to RUN_WAIT and increments each cycle in RUN_WAIT.
  - If it reaches TIMEOUT_CYCLES without des_done: error pulses 1 cycle and the block behaves as abort (next state COLLECT).
- Not defined: no counter; error is tied to 0; RUN_WAIT waits indefinitely.

Test Plan:
- Encrypt, K1=K2=K3=0x133457799BBCDFF1 (bench key store + DES model): send bytes 01 23 45 67 89 AB CD EF with decrypt_mode = 0 → three des_start pulses with key_idx 1,2,3 and des_decrypt 0,1,0 → tx bytes 85 E8 13 54 0F 0A B4 05, then busy = 0.
- Decrypt, same keys: send 85 E8 13 54 0F 0A B4 05 with decrypt_mode = 1 → key_idx 3,2,1, des_decrypt 1,0,1 → tx bytes 01 23 45 67 89 AB CD EF.
- Overrun: rx_byte_valid during RUN_WAIT and during DRAIN → one overrun pulse each; output bytes unchanged from the encrypt case.
- Abort: abort after the 4th byte, then 8 new bytes → only the new block is processed. Abort in the same cycle as the pass-2 des_done → COLLECT next cycle, no further des_start.
- Backpressure: hold tx_byte_ready low for 20 cycles in DRAIN → tx_byte stays 85 with valid high. Then 8 ready pulses → bytes in order and return to COLLECT.
- TDES_TIMEOUT_EN with TIMEOUT_CYCLES = 16: DES model never returns done → error pulses once, block returns to COLLECT, busy = 0. Without the macro, busy stays 1.
